pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Each cycle it decides, per register, whether to advance, hold or flush. The decision uses instruction-fetch and data-memory handshakes, load-use hazards, branch/jump redirects and halt.
- A small FSM tracks outstanding and completed data-memory accesses so a MEM-stage access is never issued twice and its result is never written back twice.
- It also keeps a saturating stall-cycle counter for performance checks.

Parameters:
- CNT_W, 16, width of the stall_count output.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_req  in  1  MEM-stage instruction is a load or store.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rd  in  5  EX-stage destination register.
- id_rs  in  5  ID-stage source register rs.
- id_rt  in  5  ID-stage source register rt.
- branch_mem  in  1  taken branch or jr resolved in MEM.
- jump_id  in  1  j/jal resolved in ID.
- halt_mem  in  1  halt instruction in MEM.
- pc_en  out  1  PC load enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register flushes. Flush dominates enable in every register.
- dmem_mask  out  1  datapath must deassert dREN/dWEN while high.
- halt_out  out  1  registered, sticky halt.
- stall_count  out  CNT_W  saturating count of non-advancing cycles.

Behaviour:
- Reset:
  - RST=1 on a rising CLK edge: state=RUN, halt_out=0, stall_count=0.
  - All outputs are combinational from state and inputs. In RUN with all inputs 0 (ihit=0), every en/flush is 0 and dmem_mask=0.
- FSM states: RUN, DWAIT, DDONE, HALT.
- RUN transitions:
  - halt_mem → HALT (priority over everything).
  - else mem_req & ~dhit → DWAIT.
  - else mem_req & dhit & ~ihit → DDONE.
  - else stay in RUN.
- DWAIT transitions: dhit & ihit → RUN; dhit & ~ihit → DDONE; else hold.
- DDONE transitions: ihit → RUN; else hold.
- HALT: absorbing until RST.
- advance (combinational) is true in any of these cases:
  - RUN & ~halt_mem & ihit & (~mem_req | dhit)
  - DWAIT & dhit & ihit
  - DDONE & ihit
- Output priority when advance=1:
  1. branch_mem: pc_en=1, all four en=1, if_id_flush=id_ex_flush=ex_mem_flush=1. Branch overrides load-use and jump.
  2. load_use, defined as ex_memread & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  3. jump_id: all en=1, pc_en=1, if_id_flush=1.
  4. otherwise: all en=1, pc_en=1.
  - Advancing out of DDONE: additionally mem_wb_flush=1. The completed access already reached MEM/WB and must not be captured again.
- advance=0:
  - All en=0 and all flush=0.
  - Exception: on the dhit cycle that moves to DDONE, mem_wb_en=1 so the load data is captured. Writeback of the held MEM/WB value during DDONE is idempotent.
- dmem_mask=1 only in DDONE.
- HALT: all en/flush=0, pc_en=0, halt_out=1 from the cycle after entry.
- stall_count:
  - +1 on every cycle with advance=0 and state!=HALT.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - halt_mem with dhit in RUN: HALT wins.
  - RST wins over every input, including mid-DWAIT/DDONE.

Test Plan:
- Reset: hold RST 2 cycles with random inputs → state RUN, halt_out=0, stall_count=0; with ihit=1 and other inputs 0 → all en=1, pc_en=1, flushes 0.
- Load-use: ex_memread=1, ex_rd=5, id_rs=5, ihit=1 → pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. Repeat with ex_rd=0 → no stall.
- Data wait:
  - mem_req=1, ihit=1, dhit=0 for 3 cycles → DWAIT, enables 0, stall_count=3.
  - Then dhit=1, ihit=0 → mem_wb_en=1, next state DDONE, dmem_mask=1.
  - Then ihit=1 → all en=1, mem_wb_flush=1, back to RUN.
- Branch + load-use together, ihit=1 → branch response: three flushes asserted, pc_en=1.
- Halt: halt_mem=1 with dhit=1 → next cycle halt_out=1, all en=0. Stays halted for 10 cycles regardless of inputs. RST=1 clears it.
- Saturation: CNT_W=4, ihit=0 for 20 cycles → stall_count holds 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side handshake/control bundle for pipeline_hazard_ctrl.
// master = pipeline datapath, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_req;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             branch_mem;
    logic             jump_id;
    logic             halt_mem;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             dmem_mask;
    logic             halt_out;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ihit, dhit, mem_req, ex_memread, ex_rd, id_rs, id_rt,
               branch_mem, jump_id, halt_mem,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               dmem_mask, halt_out, stall_count
    );

    modport slave (
        input  ihit, dhit, mem_req, ex_memread, ex_rd, id_rs, id_rt,
               branch_mem, jump_id, halt_mem,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               dmem_mask, halt_out, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: per-register advance/hold/flush,
// data-memory access tracking FSM, sticky halt and saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, DWAIT, DDONE, HALT} state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             advance_s;
    logic             capture_s;
    logic             load_use_s;
    logic             halt_r;
    logic [CNT_W-1:0] stall_count_r;

    logic pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s;
    logic if_id_flush_s, id_ex_flush_s, ex_mem_flush_s, mem_wb_flush_s;

    assign load_use_s = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                        ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state, advance decision and the load-data capture on the dhit-without-ihit cycle.
    always_comb begin
        next_state_s = state_r;
        advance_s    = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (bus.halt_mem) begin
                    next_state_s = HALT;
                end else if (bus.mem_req && !bus.dhit) begin
                    next_state_s = DWAIT;
                end else if (bus.mem_req && bus.dhit && !bus.ihit) begin
                    next_state_s = DDONE;
                    capture_s    = 1'b1;
                end else if (bus.ihit) begin
                    advance_s    = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            DWAIT: begin
                if (bus.dhit && bus.ihit) begin
                    next_state_s = RUN;
                    advance_s    = 1'b1;
                end else if (bus.dhit) begin
                    next_state_s = DDONE;
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = DWAIT;
                end
            end
            DDONE: begin
                if (bus.ihit) begin
                    next_state_s = RUN;
                    advance_s    = 1'b1;
                end else begin
                    next_state_s = DDONE;
                end
            end
            HALT: begin
                next_state_s = HALT;
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // Per-register enables and flushes; branch beats load-use beats jump.
    always_comb begin
        pc_en_s        = 1'b0;
        if_id_en_s     = 1'b0;
        id_ex_en_s     = 1'b0;
        ex_mem_en_s    = 1'b0;
        mem_wb_en_s    = capture_s;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_flush_s = 1'b0;
        mem_wb_flush_s = 1'b0;
        if (advance_s) begin
            ex_mem_en_s = 1'b1;
            mem_wb_en_s = 1'b1;
            // A completed access already sits in MEM/WB; do not capture it twice.
            mem_wb_flush_s = (state_r == DDONE);
            if (bus.branch_mem) begin
                pc_en_s        = 1'b1;
                if_id_en_s     = 1'b1;
                id_ex_en_s     = 1'b1;
                if_id_flush_s  = 1'b1;
                id_ex_flush_s  = 1'b1;
                ex_mem_flush_s = 1'b1;
            end else if (load_use_s) begin
                id_ex_flush_s  = 1'b1;
            end else if (bus.jump_id) begin
                pc_en_s        = 1'b1;
                if_id_en_s     = 1'b1;
                id_ex_en_s     = 1'b1;
                if_id_flush_s  = 1'b1;
            end else begin
                pc_en_s        = 1'b1;
                if_id_en_s     = 1'b1;
                id_ex_en_s     = 1'b1;
            end
        end else begin
            pc_en_s = 1'b0;
        end
    end

    // Sticky halt flag, visible the cycle after HALT is entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            halt_r <= 1'b0;
        end else begin
            halt_r <= halt_r || (next_state_s == HALT);
        end
    end

    // Saturating count of non-advancing, non-halted cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (!advance_s && (state_r != HALT) && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.pc_en        = pc_en_s;
    assign bus.if_id_en     = if_id_en_s;
    assign bus.id_ex_en     = id_ex_en_s;
    assign bus.ex_mem_en    = ex_mem_en_s;
    assign bus.mem_wb_en    = mem_wb_en_s;
    assign bus.if_id_flush  = if_id_flush_s;
    assign bus.id_ex_flush  = id_ex_flush_s;
    assign bus.ex_mem_flush = ex_mem_flush_s;
    assign bus.mem_wb_flush = mem_wb_flush_s;
    assign bus.dmem_mask    = (state_r == DDONE);
    assign bus.halt_out     = halt_r;
    assign bus.stall_count  = stall_count_r;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, scoreboard-driven bench for pipeline_hazard_ctrl (16-bit counter DUT plus a
// 4-bit counter DUT for saturation).
module tb_pipeline_hazard_ctrl;
    logic CLK;
    logic RST;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  sat_bus ();

    pipeline_hazard_ctrl #(.CNT_W(16)) dut     (.CLK(CLK), .RST(RST), .bus(bus));
    pipeline_hazard_ctrl #(.CNT_W(4))  dut_sat (.CLK(CLK), .RST(RST), .bus(sat_bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ctrl vector: {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem,mem_wb flush | dmem_mask | halt_out}
    localparam logic [10:0] NONE  = 11'b00000_0000_0_0;
    localparam logic [10:0] ADV   = 11'b11111_0000_0_0;
    localparam logic [10:0] LU    = 11'b00011_0100_0_0;
    localparam logic [10:0] JMP   = 11'b11111_1000_0_0;
    localparam logic [10:0] BR    = 11'b11111_1110_0_0;
    localparam logic [10:0] WB    = 11'b00001_0000_0_0;
    localparam logic [10:0] MASK  = 11'b00000_0000_1_0;
    localparam logic [10:0] DDADV = 11'b11111_0001_1_0;
    localparam logic [10:0] DDBR  = 11'b11111_1111_1_0;
    localparam logic [10:0] HALTV = 11'b00000_0000_0_1;

    typedef struct {
        logic [10:0] ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [10:0] ctrl_now();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                bus.dmem_mask, bus.halt_out};
    endfunction

    task automatic clear_in();
        bus.ihit = 1'b0; bus.dhit = 1'b0; bus.mem_req = 1'b0; bus.ex_memread = 1'b0;
        bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.branch_mem = 1'b0; bus.jump_id = 1'b0; bus.halt_mem = 1'b0;
    endtask

    task automatic rand_in();
        bus.ihit = 1'($urandom_range(0, 1)); bus.dhit = 1'($urandom_range(0, 1));
        bus.mem_req = 1'($urandom_range(0, 1)); bus.ex_memread = 1'($urandom_range(0, 1));
        bus.ex_rd = 5'($urandom_range(0, 31)); bus.id_rs = 5'($urandom_range(0, 31));
        bus.id_rt = 5'($urandom_range(0, 31)); bus.branch_mem = 1'($urandom_range(0, 1));
        bus.jump_id = 1'($urandom_range(0, 1)); bus.halt_mem = 1'($urandom_range(0, 1));
    endtask

    // Push the expectation for the inputs just driven, then pop and compare at the falling edge.
    task automatic chk(input string tag, input logic [10:0] ctrl, input logic [15:0] cnt);
        exp_t e;
        exp_t got_e;
        e.ctrl = ctrl;
        e.cnt  = cnt;
        sb.push_back(e);
        @(negedge CLK);
        got_e = sb.pop_front();
        n_checks++;
        assert (ctrl_now() === got_e.ctrl) n_pass++;
        else $error("FAIL %s ctrl: got %b expected %b", tag, ctrl_now(), got_e.ctrl);
        n_checks++;
        assert (bus.stall_count === got_e.cnt) n_pass++;
        else $error("FAIL %s stall_count: got %0d expected %0d", tag, bus.stall_count, got_e.cnt);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            rand_in();
            @(posedge CLK);
        end
        #1;
        RST = 1'b0;
        clear_in();
    endtask

    initial begin
        sat_bus.ihit = 1'b0; sat_bus.dhit = 1'b0; sat_bus.mem_req = 1'b0;
        sat_bus.ex_memread = 1'b0; sat_bus.ex_rd = 5'd0; sat_bus.id_rs = 5'd0;
        sat_bus.id_rt = 5'd0; sat_bus.branch_mem = 1'b0; sat_bus.jump_id = 1'b0;
        sat_bus.halt_mem = 1'b0;
        clear_in();
        RST = 1'b1;
        #2;
        do_reset(2);

        bus.ihit = 1'b1;                                   chk("reset_adv", ADV, 16'd0);
        clear_in();                                        chk("idle", NONE, 16'd0);
        bus.ihit = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
                                                           chk("lu_rs", LU, 16'd1);
        bus.id_rs = 5'd3; bus.id_rt = 5'd5;                chk("lu_rt", LU, 16'd1);
        bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
                                                           chk("lu_rd0", ADV, 16'd1);
        clear_in(); bus.ihit = 1'b1; bus.jump_id = 1'b1;   chk("jump", JMP, 16'd1);
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rt = 5'd7;
                                                           chk("jump_lu", LU, 16'd1);

        clear_in(); bus.ihit = 1'b1; bus.mem_req = 1'b1;
        chk("dwait1", NONE, 16'd1);
        chk("dwait2", NONE, 16'd2);
        chk("dwait3", NONE, 16'd3);
        bus.ihit = 1'b0; bus.dhit = 1'b1;                  chk("dhit_cap", WB, 16'd4);
        bus.dhit = 1'b0;                                   chk("ddone_hold", MASK, 16'd5);
        bus.ihit = 1'b1;                                   chk("ddone_adv", DDADV, 16'd6);
        bus.mem_req = 1'b0;                                chk("back_run", ADV, 16'd6);
        bus.mem_req = 1'b1; bus.dhit = 1'b1;               chk("mem_hit", ADV, 16'd6);
        bus.ihit = 1'b0;                                   chk("run_cap", WB, 16'd6);
        clear_in(); bus.ihit = 1'b1; bus.branch_mem = 1'b1;
                                                           chk("ddone_br", DDBR, 16'd7);
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd9; bus.id_rs = 5'd9; bus.jump_id = 1'b1;
                                                           chk("br_lu", BR, 16'd7);
        bus.ihit = 1'b0;                                   chk("br_noihit", NONE, 16'd7);
        clear_in(); bus.ihit = 1'b1; bus.mem_req = 1'b1;   chk("dwait_b", NONE, 16'd8);
        bus.dhit = 1'b1;                                   chk("dwait_both", ADV, 16'd9);
        clear_in(); bus.ihit = 1'b1;                       chk("run_again", ADV, 16'd9);

        bus.halt_mem = 1'b1; bus.dhit = 1'b1; bus.mem_req = 1'b1;
                                                           chk("halt_entry", NONE, 16'd9);
        for (int i = 0; i < 10; i++) begin
            rand_in();
            chk("halted", HALTV, 16'd10);
        end

        do_reset(1);
        bus.ihit = 1'b1;                                   chk("rst_halt", ADV, 16'd0);
        bus.mem_req = 1'b1;                                chk("dwait_c", NONE, 16'd0);
        do_reset(1);
        bus.ihit = 1'b1;                                   chk("rst_dwait", ADV, 16'd0);

        clear_in();
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
        end
        #1;
        chk("idle20", NONE, 16'd20);
        n_checks++;
        assert (sat_bus.stall_count === 4'hF) n_pass++;
        else $error("FAIL sat4: got %0d expected %0d", sat_bus.stall_count, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
